fetch_pc_gen: RTL



---
 rtl/fetch_pc_gen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: PC owner and instruction-memory request generator for fetch.
// Optional FETCH_PERF_EN adds saturating fetch/stall/redirect counters.
module fetch_pc_gen #(
   parameter int              ADDR     = 32,
   parameter int              WORD     = 32,
   parameter logic [ADDR-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_en_o,
   output logic [ADDR-1:0] imem_addr_o,
   input  logic [WORD-1:0] imem_data_i,
   output logic            v_o,
   output logic [WORD-1:0] inst_o,
   output logic [ADDR-1:0] pc_o,
   input  logic            stall_i,
   input  logic            branch_i,
   input  logic [ADDR-1:0] branch_pc_i,
   input  logic            halt_i
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetch_o,
   output logic [31:0]     perf_stall_o,
   output logic [31:0]     perf_redirect_o
`endif
);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALTED
   } state_t;

   state_t state;
   state_t state_nx;

   logic [ADDR-1:0] pc_r;
   logic            resp_v_r;
   logic [ADDR-1:0] resp_pc_r;
   logic            hold_v_r;
   logic [WORD-1:0] hold_inst_r;
   logic [ADDR-1:0] hold_pc_r;

   logic            issue;
   logic [ADDR-1:0] fetch_addr;
   logic            out_v;
   logic [WORD-1:0] out_inst;
   logic [ADDR-1:0] out_pc;

   // request generation: a redirect always issues its target immediately
   always_comb begin
      issue      = ((state == RUN) && !halt_i && !stall_i && !hold_v_r)
                   || branch_i;
      fetch_addr = branch_i ? branch_pc_i : pc_r;
   end

   assign imem_en_o   = issue;
   assign imem_addr_o = fetch_addr;

   // output mux: hold register wins over the live memory response
   always_comb begin
      out_v    = 1'b0;
      out_inst = '0;
      out_pc   = '0;
      if (hold_v_r) begin
         out_v    = 1'b1;
         out_inst = hold_inst_r;
         out_pc   = hold_pc_r;
      end else begin
         out_v    = resp_v_r;
         out_inst = imem_data_i;
         out_pc   = resp_pc_r;
      end
      if (branch_i) begin
         out_v = 1'b0;
      end
      v_o    = out_v;
      inst_o = out_v ? out_inst : '0;
      pc_o   = out_v ? out_pc : '0;
   end

   // next-state: boot for one cycle, halt only when not redirecting
   always_comb begin
      state_nx = state;
      unique case (state)
         BOOT:    state_nx = RUN;
         RUN:     if (halt_i && !branch_i) state_nx = HALTED;
         HALTED:  if (branch_i) state_nx = RUN;
         default: state_nx = BOOT;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= BOOT;
      end else begin
         state <= state_nx;
      end
   end

   // PC and in-flight request tracking
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_r      <= RESET_PC;
         resp_v_r  <= 1'b0;
         resp_pc_r <= RESET_PC;
      end else begin
         resp_v_r <= issue;
         if (issue) begin
            pc_r      <= fetch_addr + ADDR'(PC_STEP);
            resp_pc_r <= fetch_addr;
         end
      end
   end

   // skid register: catch a response the queue refused, drop it on redirect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_v_r    <= 1'b0;
         hold_inst_r <= '0;
         hold_pc_r   <= RESET_PC;
      end else if (branch_i) begin
         hold_v_r <= 1'b0;
      end else if (hold_v_r) begin
         if (!stall_i) begin
            hold_v_r <= 1'b0;
         end
      end else if (resp_v_r && stall_i) begin
         hold_v_r    <= 1'b1;
         hold_inst_r <= imem_data_i;
         hold_pc_r   <= resp_pc_r;
      end
   end

`ifdef FETCH_PERF_EN
   logic accepted;
   logic stalled;

   assign accepted = v_o && !stall_i;
   assign stalled  = v_o && stall_i;

   // saturating event counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetch_o    <= '0;
         perf_stall_o    <= '0;
         perf_redirect_o <= '0;
      end else begin
         if (accepted && perf_fetch_o != '1) begin
            perf_fetch_o <= perf_fetch_o + 32'd1;
         end
         if (stalled && perf_stall_o != '1) begin
            perf_stall_o <= perf_stall_o + 32'd1;
         end
         if (branch_i && perf_redirect_o != '1) begin
            perf_redirect_o <= perf_redirect_o + 32'd1;
         end
      end
   end
`endif

endmodule
